// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 serial-to-parallel receiver, mid-bit sampling on an oversample tick.
// Flags framing errors and parks in WAIT_HIGH until a low line recovers.
module uart_receiver #(
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       in,
    output logic [7:0] out,
    output logic       done,
    output logic       busy,
    output logic       frame_err
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] MID  = TW'(OVERSAMPLE / 2 - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    state_t                 state_q, state_d;
    logic [TW-1:0]          tick_q, tick_d;
    logic [2:0]             bit_q, bit_d;
    logic [7:0]             shift_q, shift_d, out_q, out_d;
    logic                   done_q, done_d, err_q, err_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   rx_s;

    assign rx_s      = sync_q[SYNC_STAGES-1];
    assign out       = out_q;
    assign done      = done_q;
    assign frame_err = err_q;
    assign busy      = state_q != IDLE;

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], in};
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        out_d   = out_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        if (enable) begin
            case (state_q)
                IDLE: if (!rx_s) begin
                    state_d = START;
                    tick_d  = '0;
                end
                START: if (tick_q == MID) begin
                    tick_d  = '0;
                    bit_d   = '0;
                    state_d = rx_s ? IDLE : DATA;
                end else tick_d = tick_q + TW'(1);
                DATA: if (tick_q == LAST) begin
                    tick_d  = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = STOP;
                end else tick_d = tick_q + TW'(1);
                STOP: if (tick_q == LAST) begin
                    tick_d  = '0;
                    done_d  = rx_s;
                    err_d   = !rx_s;
                    out_d   = rx_s ? shift_q : out_q;
                    state_d = rx_s ? IDLE : WAIT_HIGH;
                end else tick_d = tick_q + TW'(1);
                WAIT_HIGH: if (rx_s) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            out_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            sync_q  <= '1;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            out_q   <= out_d;
            done_q  <= done_d;
            err_q   <= err_d;
            sync_q  <= sync_d;
        end
    end
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed frames into an OVERSAMPLE=4 receiver and a gated OVERSAMPLE=16 one.
module tb_uart_receiver;
    logic       clk = 1'b0, rst = 1'b1;
    logic       enable4 = 1'b1, in4 = 1'b1, enable16 = 1'b0, in16 = 1'b1;
    logic [7:0] out4, out16;
    logic       done4, busy4, err4, done16, busy16, err16;
    int         n_chk = 0, n_pass = 0;
    int         done_cnt = 0, err_cnt = 0, busy_cnt = 0, both_cnt = 0;
    int         done16_cnt = 0, err16_cnt = 0, ph = 0;
    int         d0, e0, b0;
    logic [7:0] rx_log [0:63];
    logic [7:0] hw [0:10] = '{8'h68, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20, 8'h77, 8'h6F, 8'h72, 8'h6C, 8'h64};
    logic [7:0] d16 = 8'h77;

    uart_receiver #(.OVERSAMPLE(4), .SYNC_STAGES(2)) dut4 (
        .clk(clk), .rst(rst), .enable(enable4), .in(in4),
        .out(out4), .done(done4), .busy(busy4), .frame_err(err4));

    uart_receiver #(.OVERSAMPLE(16), .SYNC_STAGES(2)) dut16 (
        .clk(clk), .rst(rst), .enable(enable16), .in(in16),
        .out(out16), .done(done16), .busy(busy16), .frame_err(err16));

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done4) begin
            rx_log[done_cnt[5:0]] <= out4;
            done_cnt <= done_cnt + 1;
        end
        if (err4) err_cnt <= err_cnt + 1;
        if (busy4) busy_cnt <= busy_cnt + 1;
        if ((done4 && err4) || (done16 && err16)) both_cnt <= both_cnt + 1;
        if (done16) done16_cnt <= done16_cnt + 1;
        if (err16) err16_cnt <= err16_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic line4(input logic b, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            in4 = b;
        end
    endtask

    task automatic send4(input logic [7:0] d, input logic sb);
        line4(1'b0, 4);
        for (int i = 0; i < 8; i++) line4(d[i], 4);
        line4(sb, 4);
    endtask

    task automatic g16(input logic b, input logic hold);
        @(posedge clk); #1;
        in16 = b;
        enable16 = (ph % 3 == 0) && !hold;
        ph++;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out", out4, 8'h00);
        chk("rst_done", done4, 1'b0);
        chk("rst_busy", busy4, 1'b0);
        chk("rst_err", err4, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        line4(1'b1, 8);

        b0 = busy_cnt;
        line4(1'b0, 1);
        line4(1'b1, 12);
        chk("glitch_done", done_cnt, 0);
        chk("glitch_err", err_cnt, 0);
        chk("glitch_out", out4, 8'h00);
        chk("glitch_busy_seen", busy_cnt > b0, 1'b1);
        chk("glitch_busy_low", busy4, 1'b0);

        b0 = busy_cnt;
        send4(8'h68, 1'b1);
        line4(1'b1, 8);
        chk("single_out", out4, 8'h68);
        chk("single_done", done_cnt, 1);
        chk("single_err", err_cnt, 0);
        chk("single_busy_seen", busy_cnt - b0 >= 36, 1'b1);
        chk("single_busy_low", busy4, 1'b0);

        send4(8'h68, 1'b1);
        line4(1'b1, 8);
        send4(8'h55, 1'b0);
        line4(1'b0, 48);
        chk("ferr_err", err_cnt, 1);
        chk("ferr_done", done_cnt, 2);
        chk("ferr_out", out4, 8'h68);
        chk("ferr_busy_held", busy4, 1'b1);
        line4(1'b1, 12);
        chk("ferr_busy_low", busy4, 1'b0);
        send4(8'h20, 1'b1);
        line4(1'b1, 8);
        chk("after_ferr_out", out4, 8'h20);
        chk("after_ferr_done", done_cnt, 3);

        d0 = done_cnt;
        e0 = err_cnt;
        for (int i = 0; i < 11; i++) send4(hw[i], 1'b1);
        line4(1'b1, 12);
        chk("hello_count", done_cnt - d0, 11);
        chk("hello_err", err_cnt - e0, 0);
        for (int i = 0; i < 11; i++) chk($sformatf("hello_byte%0d", i), rx_log[d0 + i], hw[i]);

        line4(1'b0, 4);
        line4(1'b1, 4);
        line4(1'b1, 4);
        line4(1'b1, 4);
        line4(1'b1, 2);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_out", out4, 8'h00);
        chk("midrst_busy", busy4, 1'b0);
        chk("midrst_done", done4, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        d0 = done_cnt;
        line4(1'b1, 20);
        send4(8'h72, 1'b1);
        line4(1'b1, 8);
        chk("postrst_out", out4, 8'h72);
        chk("postrst_done", done_cnt - d0, 1);

        for (int i = 0; i < 60; i++) g16(1'b1, 1'b0);
        for (int k = 0; k < 10; k++) begin
            logic b;
            b = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : d16[k-1];
            for (int c = 0; c < ((k == 6) ? 68 : 48); c++) g16(b, k == 6 && c >= 24 && c < 44);
        end
        for (int i = 0; i < 120; i++) g16(1'b1, 1'b0);
        chk("gate_out", out16, 8'h77);
        chk("gate_done", done16_cnt, 1);
        chk("gate_err", err16_cnt, 0);
        chk("never_both", both_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
Serial-to-parallel UART receiver. It is the receive end of the link driven by uart_transmitter.
- Frame format: 8N1 (1 start bit = 0, 8 data bits LSB first, 1 stop bit = 1, idle line = 1).
- The line is sampled on an oversampling tick (enable). Each bit is sampled at its midpoint.
- Each valid byte is presented on a parallel bus with a one-cycle done strobe. Framing errors are flagged.

Parameters:
OVERSAMPLE, 16, enable ticks per bit period; must be even and >= 4
SYNC_STAGES, 2, flip-flops in the input synchronizer; must be >= 2

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous active-high reset
enable  input  1  oversample tick; logic advances only in cycles where enable=1
in  input  1  serial line, asynchronous to clk
out  output  8  last correctly received byte
done  output  1  one-clk pulse: new byte valid on out
busy  output  1  high while a frame is being received (state != IDLE)
frame_err  output  1  one-clk pulse: stop bit sampled as 0

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, tick_cnt=0, bit_idx=0, shift=0x00.
  - Synchronizer flops = 1.
  - out=0x00, done=0, busy=0, frame_err=0.
- Input path: `in` passes through SYNC_STAGES flops; rx_s is the last stage. rx_s lags `in` by SYNC_STAGES clks.
- With enable=0, state and counters hold, and done/frame_err are 0. The synchronizer runs every clk.
- States: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE:
  - enable=1 and rx_s=0 -> START, tick_cnt=0.
  - busy goes high the clk after detection.
- START:
  - Each enable increments tick_cnt.
  - At tick_cnt == OVERSAMPLE/2-1 (mid start bit), if rx_s=0 -> DATA, tick_cnt=0, bit_idx=0.
  - Otherwise it is a glitch -> IDLE, with no done and no frame_err.
- DATA:
  - Each enable increments tick_cnt.
  - At tick_cnt == OVERSAMPLE-1: shift <= {rx_s, shift[7:1]} (LSB first), tick_cnt=0, bit_idx++.
  - The sample with bit_idx==7 -> STOP.
- STOP (sampled at tick_cnt == OVERSAMPLE-1):
  - rx_s=1 -> out<=shift, done=1 for exactly one clk, -> IDLE.
  - rx_s=0 -> frame_err=1 for one clk, out unchanged, -> WAIT_HIGH.
- WAIT_HIGH: stay until an enable cycle sees rx_s=1, then -> IDLE. This prevents a break or stuck-low line from being read as new start bits. busy stays high.
- Registered outputs:
  - done/frame_err assert in the clk following the edge that samples the stop bit.
  - out updates on the same edge that done rises and holds until the next good frame.
- Back-to-back frames: a start bit immediately after a stop bit is accepted. IDLE is entered on the stop sample, and the next falling edge is detected on the next enable with rx_s=0.
- done and frame_err are never high together.
- Reset mid-frame: immediate return to reset values. A partial byte is discarded, and out reads 0x00 after reset.
- Counter widths: tick_cnt is $clog2(OVERSAMPLE) bits; bit_idx is 3 bits. Neither counter wraps except via the explicit compares above.

Test Plan:
- Single byte: OVERSAMPLE=4, enable=1 every clk, drive 0x68 as an 8N1 frame at 4 clks/bit.
  - out=0x68, exactly one done pulse, frame_err=0.
  - busy high across the frame, low after the stop sample.
- Glitch reject: in=0 for 1 clk (< OVERSAMPLE/2 ticks), then 1.
  - busy pulses briefly, no done, no frame_err, out stays 0x00.
- Framing error: receive 0x68 good, then 0x55 with stop bit=0 and the line held low for 12 more bit periods.
  - One frame_err pulse, out stays 0x68, no done, busy high until the line returns to 1.
  - Next good frame 0x20 -> out=0x20, done.
- Back-to-back stream: "hello world" (68 65 6C 6C 6F 20 77 6F 72 6C 64) with no idle gap between frames.
  - 11 done pulses with out matching each byte in order, frame_err never asserted.
- Reset mid-frame: assert rst for 1 clk during data bit 3 of 0x6F.
  - Outputs go to reset values immediately (out=0x00, busy=0, done=0).
  - A subsequent 0x72 frame is received correctly.
- Enable gating: OVERSAMPLE=16, enable pulsed 1 clk in every 3, 0x77 sent at 48 clks/bit. enable is also forced to 0 for 20 extra clks mid data bit 5, with the bit period stretched to match.
  - out=0x77, single done, no frame_err.
